// File: rtl/jb_serial_port_if.sv
// ============================================================================
// Module  : jb_serial_port_if
// Brief   : CPU-side register bus of the serial port (select, r/w, data, irq).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface jb_serial_port_if;
  logic       srlEn;
  logic       rw;
  logic [1:0] adr;
  logic [7:0] datIn;
  logic [7:0] datOut;
  logic       datOe;
  logic       irq;

  modport master (
    output srlEn, rw, adr, datIn,
    input  datOut, datOe, irq
  );

  modport slave (
    input  srlEn, rw, adr, datIn,
    output datOut, datOe, irq
  );
endinterface

`default_nettype wire

// File: rtl/jb_serial_port.sv
// ============================================================================
// Module  : jb_serial_port
// Brief   : 8N1 UART with TX/RX FIFOs, programmable divider and CPU registers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module jb_serial_port_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             clr,
  input  wire logic             push,
  input  wire logic             pop,
  input  wire logic [WIDTH-1:0] wrData,
  output logic      [WIDTH-1:0] rdData,
  output logic                  empty,
  output logic                  full
);
  localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_PW:0] c_FULL = (c_PW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_PW-1:0]  r_wp;
  logic [c_PW-1:0]  r_rp;
  logic [c_PW:0]    r_cnt;
  logic             w_pop;
  logic             w_push;

  assign empty  = (r_cnt == '0);
  assign full   = (r_cnt == c_FULL);
  assign rdData = r_mem[r_rp];
  // A push into a full FIFO is still accepted when a pop frees a slot on the same edge.
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push && !clr) r_mem[r_wp] <= wrData;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (clr) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

module jb_serial_port #(
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic       clk,
  input  wire logic       rst,
  jb_serial_port_if.slave bus,
  output logic            txd,
  input  wire logic       rxd
);
  localparam logic [1:0] c_ADR_DATA = 2'd0;
  localparam logic [1:0] c_ADR_STAT = 2'd1;
  localparam logic [1:0] c_ADR_DIV  = 2'd2;
  localparam logic [1:0] c_ADR_CTRL = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic       w_wr;
  logic       w_rd;
  logic       w_fifoClr;
  logic       w_statRd;
  logic       w_divWr;
  logic       w_tick;
  logic [7:0] r_div;
  logic [7:0] r_tickCnt;
  logic       r_rxIe;
  logic       r_txIe;
  logic       r_overrun;
  logic       r_frameErr;
  logic       r_irq;

  assign w_wr      = ~bus.srlEn & ~bus.rw;
  assign w_rd      = ~bus.srlEn & bus.rw;
  assign w_divWr   = w_wr && (bus.adr == c_ADR_DIV);
  assign w_fifoClr = w_wr && (bus.adr == c_ADR_CTRL) && bus.datIn[7];
  assign w_statRd  = w_rd && (bus.adr == c_ADR_STAT);
  assign w_tick    = (r_tickCnt == r_div);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div  <= '0;
      r_rxIe <= 1'b0;
      r_txIe <= 1'b0;
    end else begin
      if (w_divWr) r_div <= bus.datIn;
      if (w_wr && (bus.adr == c_ADR_CTRL)) begin
        r_rxIe <= bus.datIn[0];
        r_txIe <= bus.datIn[1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  r_tickCnt <= '0;
    else if (w_divWr || w_tick) r_tickCnt <= '0;
    else                       r_tickCnt <= r_tickCnt + 1'b1;
  end

  // ------------------------------------------------------------------ TX path
  logic       w_txPush;
  logic       w_txPop;
  logic [7:0] w_txHead;
  logic       w_txEmpty;
  logic       w_txFull;
  state_t     r_txSt;
  logic [3:0] r_txTickCnt;
  logic [2:0] r_txBitCnt;
  logic [7:0] r_txShift;

  assign w_txPush = w_wr && (bus.adr == c_ADR_DATA);
  assign w_txPop  = w_tick && !w_fifoClr && !w_txEmpty &&
                    ((r_txSt == S_IDLE) || ((r_txSt == S_STOP) && (r_txTickCnt == 4'd15)));

  jb_serial_port_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_txFifo (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_fifoClr),
    .push   (w_txPush),
    .pop    (w_txPop),
    .wrData (bus.datIn),
    .rdData (w_txHead),
    .empty  (w_txEmpty),
    .full   (w_txFull)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_txSt      <= S_IDLE;
      r_txTickCnt <= '0;
      r_txBitCnt  <= '0;
      r_txShift   <= '0;
      txd         <= 1'b1;
    end else if (w_fifoClr) begin
      r_txSt      <= S_IDLE;
      r_txTickCnt <= '0;
      txd         <= 1'b1;
    end else if (w_tick) begin
      case (r_txSt)
        S_IDLE: begin
          if (!w_txEmpty) begin
            r_txSt      <= S_START;
            r_txShift   <= w_txHead;
            r_txTickCnt <= '0;
            txd         <= 1'b0;
          end
        end
        S_START: begin
          r_txTickCnt <= r_txTickCnt + 1'b1;
          if (r_txTickCnt == 4'd15) begin
            r_txSt     <= S_DATA;
            r_txBitCnt <= '0;
            txd        <= r_txShift[0];
          end
        end
        S_DATA: begin
          r_txTickCnt <= r_txTickCnt + 1'b1;
          if (r_txTickCnt == 4'd15) begin
            if (r_txBitCnt == 3'd7) begin
              r_txSt <= S_STOP;
              txd    <= 1'b1;
            end else begin
              r_txShift  <= {1'b0, r_txShift[7:1]};
              r_txBitCnt <= r_txBitCnt + 1'b1;
              txd        <= r_txShift[1];
            end
          end
        end
        default: begin
          r_txTickCnt <= r_txTickCnt + 1'b1;
          if (r_txTickCnt == 4'd15) begin
            if (!w_txEmpty) begin
              r_txSt    <= S_START;
              r_txShift <= w_txHead;
              txd       <= 1'b0;
            end else begin
              r_txSt <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

  // ------------------------------------------------------------------ RX path
  logic [1:0] r_rxSync;
  logic       r_rxPrev;
  logic       w_rxS;
  state_t     r_rxSt;
  logic [3:0] r_rxTickCnt;
  logic [2:0] r_rxBitCnt;
  logic [7:0] r_rxShift;
  logic       w_stopSample;
  logic       w_rxPushReq;
  logic       w_rxPop;
  logic [7:0] w_rxHead;
  logic       w_rxEmpty;
  logic       w_rxFull;
  logic       w_overrunSet;
  logic       w_frameErrSet;

  assign w_rxS         = r_rxSync[1];
  assign w_stopSample  = (r_rxSt == S_STOP) && w_tick && (r_rxTickCnt == 4'd15) && !w_fifoClr;
  assign w_rxPushReq   = w_stopSample && w_rxS;
  assign w_frameErrSet = w_stopSample && !w_rxS;
  assign w_rxPop       = w_rd && (bus.adr == c_ADR_DATA);
  assign w_overrunSet  = w_rxPushReq && w_rxFull && !(w_rxPop && !w_rxEmpty);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rxSync <= 2'b11;
      r_rxPrev <= 1'b1;
    end else begin
      r_rxSync <= {r_rxSync[0], rxd};
      r_rxPrev <= r_rxSync[1];
    end
  end

  jb_serial_port_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rxFifo (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_fifoClr),
    .push   (w_rxPushReq),
    .pop    (w_rxPop),
    .wrData (r_rxShift),
    .rdData (w_rxHead),
    .empty  (w_rxEmpty),
    .full   (w_rxFull)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rxSt      <= S_IDLE;
      r_rxTickCnt <= '0;
      r_rxBitCnt  <= '0;
      r_rxShift   <= '0;
    end else if (w_fifoClr) begin
      r_rxSt      <= S_IDLE;
      r_rxTickCnt <= '0;
    end else begin
      case (r_rxSt)
        S_IDLE: begin
          if (r_rxPrev && !w_rxS) begin
            r_rxSt      <= S_START;
            r_rxTickCnt <= '0;
          end
        end
        S_START: begin
          // Mid start bit: a line back high means the edge was a glitch.
          if (w_tick) begin
            r_rxTickCnt <= r_rxTickCnt + 1'b1;
            if (r_rxTickCnt == 4'd7) begin
              r_rxTickCnt <= '0;
              r_rxBitCnt  <= '0;
              r_rxSt      <= w_rxS ? S_IDLE : S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_rxTickCnt <= r_rxTickCnt + 1'b1;
            if (r_rxTickCnt == 4'd15) begin
              r_rxShift  <= {w_rxS, r_rxShift[7:1]};
              r_rxBitCnt <= r_rxBitCnt + 1'b1;
              if (r_rxBitCnt == 3'd7) r_rxSt <= S_STOP;
            end
          end
        end
        default: begin
          if (w_tick) begin
            r_rxTickCnt <= r_rxTickCnt + 1'b1;
            if (r_rxTickCnt == 4'd15) r_rxSt <= S_IDLE;
          end
        end
      endcase
    end
  end

  // ------------------------------------------------------- flags, irq, reads
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overrun  <= 1'b0;
      r_frameErr <= 1'b0;
      r_irq      <= 1'b1;
    end else begin
      if (w_statRd) begin
        r_overrun  <= 1'b0;
        r_frameErr <= 1'b0;
      end
      if (w_overrunSet)  r_overrun  <= 1'b1;
      if (w_frameErrSet) r_frameErr <= 1'b1;
      r_irq <= ~((r_rxIe && !w_rxEmpty) || (r_txIe && w_txEmpty));
    end
  end

  logic       w_txIdle;
  logic [7:0] w_status;

  assign w_txIdle  = w_txEmpty && (r_txSt == S_IDLE);
  assign w_status  = {~r_irq, 1'b0, r_frameErr, r_overrun, w_txFull, w_txIdle, w_rxFull, ~w_rxEmpty};
  assign bus.datOe = ~bus.srlEn & bus.rw;
  assign bus.irq   = r_irq;

  always_comb begin
    bus.datOut = 8'h00;
    case (bus.adr)
      c_ADR_DATA: bus.datOut = w_rxEmpty ? 8'h00 : w_rxHead;
      c_ADR_STAT: bus.datOut = w_status;
      c_ADR_DIV:  bus.datOut = r_div;
      default:    bus.datOut = {6'b0, r_txIe, r_rxIe};
    endcase
  end
endmodule

`default_nettype wire

// File: doc/jb_serial_port.md
JB_SERIAL_PORT -- requirements
Module: jb_serial_port

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, entries in each of the TX and RX FIFOs; power of 2 only.
REQ-002 SHALL have port clk, input, 1: system clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port srlEn, input, 1: active-low chip select from the address decoder ($9F6x).
REQ-005 SHALL have port rw, input, 1: 1 = CPU read, 0 = CPU write.
REQ-006 SHALL have port adr, input, 2: register select, taken from adrBusLo[1:0].
REQ-007 SHALL have port datIn, input, 8: CPU write data.
REQ-008 SHALL have port datOut, output, 8: read data, combinational from adr.
REQ-009 SHALL have port datOe, output, 1: high when ~srlEn && rw.
REQ-010 SHALL have port txd, output, 1: serial out, idle high.
REQ-011 SHALL have port rxd, input, 1: serial in, asynchronous.
REQ-012 SHALL have port irq, output, 1: active-low interrupt request.

Function
REQ-013 Each rising edge with srlEn=0 SHALL count as one access: write if rw=0, read if rw=1.
REQ-014 Register map: 0 DATA; 1 STATUS (read-only); 2 DIV; 3 CTRL (bit0 rxIe, bit1 txIe, bit7 fifoClr, which self-clears).
REQ-015 A DATA write SHALL push datIn to the TX FIFO; a write while the FIFO is full SHALL be dropped.
REQ-016 A DATA read SHALL present the RX FIFO head and pop it on that edge; a read while empty SHALL return 8'h00 and pop nothing.
REQ-017 STATUS bits: 0 rxAvail, 1 rxFull, 2 txIdle (FIFO empty and shifter idle), 3 txFull, 4 overrun, 5 frameErr, 6 0, 7 irq active.
REQ-018 A STATUS read SHALL clear overrun and frameErr on that edge; a set event on the same edge SHALL win over the clear.
REQ-019 The tick generator SHALL emit one tick every DIV+1 clocks (bit rate = clk/(16*(DIV+1))); a DIV write SHALL restart the tick counter.
REQ-020 TX FSM states: IDLE, START, DATA, STOP; 16 ticks per bit; frame is 8N1, LSB first.
REQ-021 From IDLE with the FIFO non-empty, the FSM SHALL pop on the next tick and drive the start bit; after STOP it SHALL return to IDLE, or go straight to START if data is pending.
REQ-022 rxd SHALL be synchronised through 2 flops before use.
REQ-023 RX FSM states: IDLE, START, DATA, STOP; a falling edge seen in IDLE SHALL enter START.
REQ-024 At tick 8, START SHALL return to IDLE if the line is high (glitch reject), else continue; each data bit SHALL be sampled at mid-bit, 16 ticks apart.
REQ-025 If the stop bit samples 0, frameErr SHALL be set and the byte discarded; otherwise the byte SHALL be pushed.
REQ-026 A push into a full RX FIFO SHALL set overrun and discard the new byte.
REQ-027 A simultaneous push and pop on either FIFO SHALL both take effect, with the count unchanged; FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 irq SHALL be 0 iff (rxIe && rxAvail) || (txIe && TX FIFO empty), registered with 1 cycle of latency.
REQ-029 fifoClr=1 SHALL empty both FIFOs and return both FSMs to IDLE with txd=1; DIV, CTRL enables and flags SHALL be kept.

Reset
REQ-030 When rst=0, the block SHALL immediately force: txd=1, irq=1, DIV=0, CTRL=0, FIFOs empty, both FSMs IDLE, flags 0, synchroniser flops 1.
REQ-031 rst asserted mid-frame SHALL abort the frame: txd goes high at once and the partial RX byte is discarded.
REQ-032 The first access SHALL be legal on the first rising edge after rst deasserts.

Verification
REQ-033 DIV=0, write DATA=8'hA5 -> txd shows start, then 1,0,1,0,0,1,0,1, then stop, 16 clocks per bit; txIdle=1 at 160 clk.
REQ-034 Loop txd to rxd, write 8'h3C -> rxAvail=1 after the frame; DATA read returns 8'h3C; rxAvail=0 afterwards.
REQ-035 Inject 5 frames without reading (FIFO_DEPTH=4) -> rxFull=1, overrun=1, reads return the first 4 bytes, STATUS read clears overrun.
REQ-036 Frame with stop bit=0 -> frameErr=1, no push; a 4-clock low glitch on rxd -> no frame received.
REQ-037 Write 5 bytes fast -> 4 sent, 5th dropped, txFull=1 until the first pop; CTRL=8'h02 -> irq=0 once the TX FIFO is empty.
REQ-038 rst pulse mid-TX at bit 3 -> txd=1 immediately, FIFOs empty, STATUS=8'h04.
